// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared definitions for the PWM brightness-level controller.
//   state_e      : controller FSM states (MANUAL=0, FADE_UP=1, FADE_DOWN=2)
//   LEVEL_PORT_W : width of the level port driven into the PWM datapath
//   level_w()    : internal level arithmetic width for a given level count
package pwm_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } state_e;

  localparam int LEVEL_PORT_W = 3;

  // A single-level controller still needs a one-bit register.
  function automatic int level_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- conditions one active-low push button.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn   : raw button, active-low, asynchronous to clk
//   press : one-cycle pulse per debounced released->pressed transition
// A 2-flop synchronizer feeds a counter that must see 2**DEBOUNCE_W
// consecutive differing samples before the debounced state flips; the
// transition is then registered once more so the pulse lands a fixed
// 2 + 2**DEBOUNCE_W + 1 cycles after the button edge.
module btn_debounce #(
  parameter int DEBOUNCE_W = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic                  sync_p0;
  logic                  sync_p1;
  logic                  db_p2;
  logic                  db_p3;
  logic [DEBOUNCE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      db_p2   <= 1'b1;
      db_p3   <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // synchronizer
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // debounce window: any sample that agrees with db_p2 restarts it
      if (sync_p1 != db_p2) begin
        if (cnt == '1) begin
          db_p2 <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + DEBOUNCE_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      // edge detect: falling debounced level is a press
      db_p3 <= db_p2;
      press <= db_p3 & ~db_p2;
    end
  end

endmodule

// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl -- brightness level controller for a PWM LED driver.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   up      : button, active-low, async: next level (wraps)
//   down    : button, active-low, async: previous level (wraps)
//   mode    : button, active-low, async: toggle auto-fade
//   level   : current brightness level, 0..LED_COUNT-1
//   fade_on : high while auto-fading
//   step    : one-cycle pulse in the cycle level shows a new value
// In MANUAL the buttons step the level directly. Mode enters a triangle
// auto-fade that moves one level every 2**FADE_W cycles; any press while
// fading drops back to MANUAL at the current level.
module pwm_level_ctrl
  import pwm_pkg::*;
#(
  parameter int LED_COUNT  = 6,
  parameter int DEBOUNCE_W = 21,
  parameter int FADE_W     = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up,
  input  logic                    down,
  input  logic                    mode,
  output logic [LEVEL_PORT_W-1:0] level,
  output logic                    fade_on,
  output logic                    step
);

  localparam int            LW      = level_w(LED_COUNT);
  localparam logic [LW-1:0] LVL_MAX = LW'(LED_COUNT - 1);

  function automatic logic [LW-1:0] lvl_inc(input logic [LW-1:0] l);
    return (l == LVL_MAX) ? '0 : l + LW'(1);
  endfunction

  function automatic logic [LW-1:0] lvl_dec(input logic [LW-1:0] l);
    return (l == '0) ? LVL_MAX : l - LW'(1);
  endfunction

  logic up_ev;
  logic down_ev;
  logic mode_ev;

  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (up),
    .press (up_ev)
  );

  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (down),
    .press (down_ev)
  );

  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (mode),
    .press (mode_ev)
  );

  state_e            state_p0;
  state_e            state_d;
  logic [LW-1:0]     lvl_p0;
  logic [LW-1:0]     lvl_d;
  logic [FADE_W-1:0] fade_cnt_p0;
  logic [FADE_W-1:0] fade_cnt_d;
  logic              step_p0;
  logic              step_d;
  logic              tick;
  logic              exit_ev;
  logic [LW-1:0]     lvl_up;
  logic [LW-1:0]     lvl_dn;

  assign tick    = (fade_cnt_p0 == '1);
  // up+down together cancel out, so only a lone one (or mode) leaves a fade
  assign exit_ev = mode_ev | (up_ev ^ down_ev);
  assign lvl_up  = lvl_inc(lvl_p0);
  assign lvl_dn  = lvl_dec(lvl_p0);

  always_comb begin
    state_d    = state_p0;
    lvl_d      = lvl_p0;
    fade_cnt_d = fade_cnt_p0;
    step_d     = 1'b0;
    case (state_p0)
      MANUAL: begin
        fade_cnt_d = '0;
        if (mode_ev) begin
          state_d = (lvl_p0 == LVL_MAX) ? FADE_DOWN : FADE_UP;
        end else if (up_ev && !down_ev) begin
          lvl_d  = lvl_up;
          step_d = 1'b1;
        end else if (down_ev && !up_ev) begin
          lvl_d  = lvl_dn;
          step_d = 1'b1;
        end
      end
      FADE_UP: begin
        if (exit_ev) begin
          state_d    = MANUAL;
          fade_cnt_d = '0;
        end else begin
          fade_cnt_d = fade_cnt_p0 + FADE_W'(1);
          if (tick) begin
            lvl_d  = lvl_up;
            step_d = 1'b1;
            if (lvl_up == LVL_MAX) state_d = FADE_DOWN;
          end
        end
      end
      FADE_DOWN: begin
        if (exit_ev) begin
          state_d    = MANUAL;
          fade_cnt_d = '0;
        end else begin
          fade_cnt_d = fade_cnt_p0 + FADE_W'(1);
          if (tick) begin
            lvl_d  = lvl_dn;
            step_d = 1'b1;
            if (lvl_dn == '0) state_d = FADE_UP;
          end
        end
      end
      default: begin
        state_d    = MANUAL;
        fade_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= MANUAL;
      lvl_p0      <= '0;
      fade_cnt_p0 <= '0;
      step_p0     <= 1'b0;
    end else begin
      state_p0    <= state_d;
      lvl_p0      <= lvl_d;
      fade_cnt_p0 <= fade_cnt_d;
      step_p0     <= step_d;
    end
  end

  assign level   = LEVEL_PORT_W'(lvl_p0);
  assign fade_on = (state_p0 != MANUAL);
  assign step    = step_p0;

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// tb_pwm_level_ctrl -- self-checking bench for pwm_level_ctrl with
// DEBOUNCE_W=3, FADE_W=4, LED_COUNT=6. A behavioural model predicts
// level/step/fade_on every cycle; literal expectations pin the model.
module tb_pwm_level_ctrl;

  localparam int LC  = 6;
  localparam int DBW = 3;
  localparam int FW  = 4;
  localparam int N   = 1 << DBW;
  localparam int FP  = 1 << FW;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       up   = 1'b1;
  logic       down = 1'b1;
  logic       mode = 1'b1;
  logic [2:0] level;
  logic       fade_on;
  logic       step;

  pwm_level_ctrl #(.LED_COUNT(LC), .DEBOUNCE_W(DBW), .FADE_W(FW)) dut (
    .clk     (clk),
    .rst     (rst),
    .up      (up),
    .down    (down),
    .mode    (mode),
    .level   (level),
    .fade_on (fade_on),
    .step    (step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // hist[b][i] = button b as sampled i edges ago (1 = released).
  // A debounced flip happens when the samples from 2..N+1 edges ago all
  // disagree with the debounced value; a press reaches the FSM 2 edges later.
  bit hist [3][N+2];
  bit db_m [3];
  bit fell1 [3];
  bit fell2 [3];
  bit ev_m [3];
  bit btn_m [3];
  bit all_diff;
  int m_state = 0;   // 0 manual, 1 fading up, 2 fading down
  int m_level = 0;
  int m_t0 = 0;
  bit m_step = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i < N + 2; i++) hist[b][i] = 1'b1;
        db_m[b] = 1'b1; fell1[b] = 1'b0; fell2[b] = 1'b0;
      end
      m_state = 0; m_level = 0; m_t0 = 0; m_step = 0;
    end else begin
      btn_m[0] = up; btn_m[1] = down; btn_m[2] = mode;
      for (int b = 0; b < 3; b++) begin
        ev_m[b]  = fell2[b];
        fell2[b] = fell1[b];
        fell1[b] = 1'b0;
        for (int i = N + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = btn_m[b];
        all_diff = 1'b1;
        for (int i = 2; i < N + 2; i++) if (hist[b][i] == db_m[b]) all_diff = 1'b0;
        if (all_diff) begin
          db_m[b]  = ~db_m[b];
          fell1[b] = ~db_m[b];
        end
      end
      m_step = 1'b0;
      if (m_state == 0) begin
        if (ev_m[2]) begin
          m_state = (m_level == LC - 1) ? 2 : 1;
          m_t0    = cyc;
        end else if (ev_m[0] && !ev_m[1]) begin
          m_level = (m_level + 1) % LC; m_step = 1'b1;
        end else if (ev_m[1] && !ev_m[0]) begin
          m_level = (m_level + LC - 1) % LC; m_step = 1'b1;
        end
      end else if (ev_m[2] || (ev_m[0] != ev_m[1])) begin
        m_state = 0;
      end else if (((cyc - m_t0) % FP) == 0) begin
        m_step = 1'b1;
        if (m_state == 1) begin
          m_level = m_level + 1;
          if (m_level == LC - 1) m_state = 2;
        end else begin
          m_level = m_level - 1;
          if (m_level == 0) m_state = 1;
        end
      end
    end
  end

  // ---------------- comparison ----------------
  int    total = 0;
  int    bad = 0;
  string lit_name = "";
  int    lit_lvl = 0;
  int    lit_step = 0;
  int    lit_fade = 0;
  int    lit_seq = 0;
  int    lit_done = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    chk("level", int'(level), m_level);
    chk("step", int'(step), int'(m_step));
    chk("fade_on", int'(fade_on), int'(m_state != 0));
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      chk({lit_name, ".level"}, int'(level), lit_lvl);
      chk({lit_name, ".step"}, int'(step), lit_step);
      chk({lit_name, ".fade_on"}, int'(fade_on), lit_fade);
      chk({lit_name, ".model_level"}, m_level, lit_lvl);
      chk({lit_name, ".model_fade"}, int'(m_state != 0), lit_fade);
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(input string nm, input int l, input int s, input int f);
    lit_name = nm; lit_lvl = l; lit_step = s; lit_fade = f;
    lit_seq++;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) hold(1);
  endtask

  task automatic drive(input int mask);
    up   = ~mask[0];
    down = ~mask[1];
    mode = ~mask[2];
  endtask

  task automatic press(input int mask, input int hl, input int gap);
    hold(1);
    drive(mask);
    hold(hl);
    drive(0);
    hold(gap);
  endtask

  int e;
  int r;
  int msk;

  initial begin
    hold(3);
    lit("reset", 0, 0, 0);
    hold(1);
    rst = 1'b0;
    hold(2);

    // first press: exact 12-cycle latency
    hold(1); e = cyc; up = 1'b0;
    tick_to(e + 11); lit("lat_pre", 0, 0, 0);
    tick_to(e + 12); lit("lat_edge", 1, 1, 0);
    tick_to(e + 13); lit("lat_post", 1, 0, 0);
    tick_to(e + 20); up = 1'b1;
    hold(20);
    press(1, 20, 20);
    press(1, 20, 20);
    lit("up3", 3, 0, 0);

    // wrap both ways
    press(1, 20, 20);
    press(1, 20, 20);
    lit("at5", 5, 0, 0);
    press(1, 20, 20);
    lit("wrap_up", 0, 0, 0);
    press(2, 20, 20);
    lit("wrap_down", 5, 0, 0);

    // bounce: never 8 consecutive low samples
    for (int i = 0; i < 6; i++) begin
      up = 1'b0; hold(4);
      up = 1'b1; hold(1);
    end
    hold(20);
    lit("bounce", 5, 0, 0);
    up = 1'b0; hold(10); up = 1'b1; hold(20);
    lit("hold10", 0, 0, 0);

    // auto-fade triangle, then exit by down
    hold(1); e = cyc; mode = 1'b0;
    tick_to(e + 12);  lit("fade_entry", 0, 0, 1);
    tick_to(e + 20);  mode = 1'b1;
    tick_to(e + 91);  lit("fade_pre5", 4, 0, 1);
    tick_to(e + 92);  lit("fade_top", 5, 1, 1);
    tick_to(e + 180); lit("fade_bottom", 0, 0, 1);
    tick_to(e + 181); down = 1'b0;
    tick_to(e + 193); lit("fade_exit", 1, 0, 0);
    tick_to(e + 201); down = 1'b1;
    hold(20);
    lit("fade_hold", 1, 0, 0);

    // up+down together, then mode+up together
    hold(1); e = cyc; up = 1'b0; down = 1'b0;
    tick_to(e + 12); lit("updown", 1, 0, 0);
    tick_to(e + 20); up = 1'b1; down = 1'b1;
    hold(20);
    hold(1); e = cyc; up = 1'b0; mode = 1'b0;
    tick_to(e + 12); lit("mode_up", 1, 0, 1);
    tick_to(e + 20); up = 1'b1; mode = 1'b1;
    tick_to(e + 45); lit("fade_at3", 3, 0, 1);

    // reset mid-fade
    hold(1);
    rst = 1'b1;
    lit("rst_mid", 0, 0, 0);
    hold(3);
    rst = 1'b0;
    hold(60);
    lit("rst_after", 0, 0, 0);

    // reset mid-debounce discards the pending press
    hold(1); up = 1'b0;
    hold(6); rst = 1'b1; up = 1'b1;
    hold(2); rst = 1'b0;
    hold(40);
    lit("rst_debounce", 0, 0, 0);

    // randomized activity
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       msk = 1;
      else if (r < 7)  msk = 2;
      else if (r == 7) msk = 4;
      else if (r == 8) msk = 3;
      else             msk = 5;
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 3; j++) begin
          drive(msk); hold($urandom_range(1, 7));
          drive(0);   hold($urandom_range(1, 2));
        end
      end
      press(msk, $urandom_range(1, 16), $urandom_range(0, 30));
      if ($urandom_range(0, 4) == 0) hold($urandom_range(20, 80));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1; hold($urandom_range(1, 2)); rst = 1'b0;
      end
    end

    hold(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
